// File: rtl/instr_pkg.sv
// Shared types for the ROM-driven I2C instruction sequencer.
package instr_pkg;

   typedef enum logic [7:0] {
      OpNop   = 8'h00,
      OpI2cRd = 8'h01,
      OpI2cWr = 8'h02
   } op_e;

   typedef struct packed {
      logic [7:0] op;
      logic [7:0] dev;
      logic [7:0] regaddr;
      logic [7:0] data;
   } instr_t;

   localparam logic [3:0] FaultRomErr    = 4'd1;
   localparam logic [3:0] FaultIllegalOp = 4'd2;
   localparam logic [3:0] FaultNack      = 4'd3;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StIssue,
      StWait,
      StNext,
      StFault
   } seq_state_e;

endpackage

// File: rtl/instr_sequencer.sv
// Walks the instruction ROM from address 0, issues I2C commands over valid/ready and
// returns read bytes; stops in a sticky fault on ROM errors, illegal opcodes or NACKs.
module instr_sequencer
   import instr_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned PROG_LEN = 2,
   parameter bit          LOOP     = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   input  logic [3:0]        rom_err,
   output logic              i2c_cmd_valid,
   input  logic              i2c_cmd_ready,
   output logic              i2c_cmd_rw,
   output logic [7:0]        i2c_dev,
   output logic [7:0]        i2c_reg,
   output logic [7:0]        i2c_wdata,
   input  logic              i2c_done,
   input  logic              i2c_ack_err,
   input  logic [7:0]        i2c_rdata,
   output logic              rd_valid,
   output logic [7:0]        rd_data,
   output logic              busy,
   output logic              seq_done,
   output logic              fault,
   output logic [3:0]        fault_code
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PROG_LEN - 1);

   seq_state_e        r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic              r_rw, w_rw_nxt;
   logic [7:0]        r_dev, w_dev_nxt;
   logic [7:0]        r_reg, w_reg_nxt;
   logic [7:0]        r_wdata, w_wdata_nxt;
   logic [7:0]        r_rd_data, w_rd_data_nxt;
   logic              r_rd_valid, w_rd_valid_nxt;
   logic              r_seq_done, w_seq_done_nxt;
   logic              r_fault, w_fault_nxt;
   logic [3:0]        r_fault_code, w_fault_code_nxt;
   logic              w_complete;
   instr_t            w_instr;

   assign w_instr = instr_t'(rom_data);

   always_comb begin
      w_state_nxt      = r_state;
      w_addr_nxt       = r_addr;
      w_rw_nxt         = r_rw;
      w_dev_nxt        = r_dev;
      w_reg_nxt        = r_reg;
      w_wdata_nxt      = r_wdata;
      w_rd_data_nxt    = r_rd_data;
      w_rd_valid_nxt   = 1'b0;
      w_seq_done_nxt   = 1'b0;
      w_fault_nxt      = r_fault;
      w_fault_code_nxt = r_fault_code;
      w_complete       = 1'b0;

      unique case (r_state)
         StIdle, StFault: begin
            if (start) begin
               w_state_nxt      = StFetch;
               w_addr_nxt       = '0;
               w_fault_nxt      = 1'b0;
               w_fault_code_nxt = '0;
            end
         end
         StFetch: w_state_nxt = StDecode;
         StDecode: begin
            if (rom_err != '0) begin
               w_state_nxt      = StFault;
               w_fault_nxt      = 1'b1;
               w_fault_code_nxt = FaultRomErr;
            end else begin
               case (w_instr.op)
                  OpNop: w_state_nxt = StNext;
                  OpI2cRd, OpI2cWr: begin
                     w_state_nxt = StIssue;
                     w_rw_nxt    = (w_instr.op == OpI2cRd);
                     w_dev_nxt   = w_instr.dev;
                     w_reg_nxt   = w_instr.regaddr;
                     w_wdata_nxt = w_instr.data;
                  end
                  default: begin
                     w_state_nxt      = StFault;
                     w_fault_nxt      = 1'b1;
                     w_fault_code_nxt = FaultIllegalOp;
                  end
               endcase
            end
         end
         StIssue: begin
            if (i2c_cmd_ready) begin
               w_state_nxt = StWait;
               w_complete  = i2c_done;  // master may finish in the handshake cycle itself
            end
         end
         StWait: w_complete = i2c_done;
         StNext: begin
            if (r_addr == LastAddr) begin
               w_addr_nxt = '0;
               if (LOOP) begin
                  w_state_nxt = StFetch;
               end else begin
                  w_state_nxt    = StIdle;
                  w_seq_done_nxt = 1'b1;
               end
            end else begin
               w_addr_nxt  = r_addr + ADDR_W'(1);
               w_state_nxt = StFetch;
            end
         end
         default: w_state_nxt = StIdle;
      endcase

      if (w_complete) begin
         if (i2c_ack_err) begin
            w_state_nxt      = StFault;
            w_fault_nxt      = 1'b1;
            w_fault_code_nxt = FaultNack;
         end else begin
            w_state_nxt = StNext;
            if (r_rw) begin
               w_rd_data_nxt  = i2c_rdata;
               w_rd_valid_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= StIdle;
         r_addr       <= '0;
         r_rw         <= 1'b0;
         r_dev        <= '0;
         r_reg        <= '0;
         r_wdata      <= '0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
         r_seq_done   <= 1'b0;
         r_fault      <= 1'b0;
         r_fault_code <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_rw         <= w_rw_nxt;
         r_dev        <= w_dev_nxt;
         r_reg        <= w_reg_nxt;
         r_wdata      <= w_wdata_nxt;
         r_rd_data    <= w_rd_data_nxt;
         r_rd_valid   <= w_rd_valid_nxt;
         r_seq_done   <= w_seq_done_nxt;
         r_fault      <= w_fault_nxt;
         r_fault_code <= w_fault_code_nxt;
      end
   end

   assign rom_addr      = r_addr;
   assign i2c_cmd_valid = (r_state == StIssue);
   assign i2c_cmd_rw    = r_rw;
   assign i2c_dev       = r_dev;
   assign i2c_reg       = r_reg;
   assign i2c_wdata     = r_wdata;
   assign rd_valid      = r_rd_valid;
   assign rd_data       = r_rd_data;
   assign busy          = (r_state != StIdle) && (r_state != StFault);
   assign seq_done      = r_seq_done;
   assign fault         = r_fault;
   assign fault_code    = r_fault_code;

endmodule
